// File: rtl/expr_pkg.sv
// ---------------------------------------------------------------------------
// expr_pkg
// Shared constants for the expression-solver datapath: the default data
// width, the select codes for the three datapath multiplexers and the ALU
// operation codes.  Imported by expr_alu and expr_datapath.
// ---------------------------------------------------------------------------
package expr_pkg;

   localparam int DEFAULT_WIDTH = 8;

   // ALU operand A select (M0)
   localparam logic [1:0] SEL_A_X    = 2'b00;
   localparam logic [1:0] SEL_A_S    = 2'b01;
   localparam logic [1:0] SEL_A_HR   = 2'b10;
   localparam logic [1:0] SEL_A_ZERO = 2'b11;

   // ALU operand B select (M1)
   localparam logic [1:0] SEL_B_C    = 2'b00;
   localparam logic [1:0] SEL_B_A    = 2'b01;
   localparam logic [1:0] SEL_B_B    = 2'b10;
   localparam logic [1:0] SEL_B_X    = 2'b11;

   // S register load source select (M2)
   localparam logic [1:0] SEL_S_ALU  = 2'b00;
   localparam logic [1:0] SEL_S_X    = 2'b01;
   localparam logic [1:0] SEL_S_HR   = 2'b10;
   localparam logic [1:0] SEL_S_ZERO = 2'b11;

   // ALU operation (H)
   localparam logic OP_ADD = 1'b0;
   localparam logic OP_MUL = 1'b1;

endpackage

// File: rtl/expr_alu.sv
// ---------------------------------------------------------------------------
// expr_alu
// Combinational add/multiply shared by the datapath.  The full result is
// formed at 2*WIDTH bits so that any carry or product bit at or above WIDTH
// flags an overflow.
// Optional feature macro: SATURATE_EN -- when defined, an overflowing result
// is clamped to all-ones instead of wrapping to its low WIDTH bits.
//
// Ports:
//   op      in   1      operation: OP_ADD or OP_MUL
//   opa     in   WIDTH  operand A
//   opb     in   WIDTH  operand B
//   result  out  WIDTH  value to be written into S/Hr
//   ovf     out  1      full result does not fit in WIDTH bits
// ---------------------------------------------------------------------------
module expr_alu
   import expr_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             op,
   input  logic [WIDTH-1:0] opa,
   input  logic [WIDTH-1:0] opb,
   output logic [WIDTH-1:0] result,
   output logic             ovf
);

   logic [2*WIDTH-1:0] opa_wide;
   logic [2*WIDTH-1:0] opb_wide;
   logic [2*WIDTH-1:0] full;

   always_comb begin
      opa_wide = {{WIDTH{1'b0}}, opa};
      opb_wide = {{WIDTH{1'b0}}, opb};
      if (op == OP_MUL) begin
         full = opa_wide * opb_wide;
      end else begin
         full = opa_wide + opb_wide;
      end
      ovf = |full[2*WIDTH-1:WIDTH];
`ifdef SATURATE_EN
      result = ovf ? {WIDTH{1'b1}} : full[WIDTH-1:0];
`else
      result = full[WIDTH-1:0];
`endif
   end

endmodule

// File: rtl/expr_datapath.sv
// ---------------------------------------------------------------------------
// expr_datapath
// Datapath end of the expression solver.  The external controller drives
// load strobes and mux selects; this block holds the working registers
// X, S and Hr, one shared ALU (expr_alu), a sticky overflow flag for the
// evaluation in progress, and a result register that captures S on the
// rising edge of the controller's completed flag.
// Optional feature macro: SATURATE_EN (handled inside expr_alu).
//
// Ports:
//   clk           in   1      system clock, rising edge
//   rst           in   1      asynchronous active-low reset
//   LX, LS, LH    in   1      load strobes for X, S and Hr
//   H             in   1      ALU op (1 = multiply, 0 = add)
//   M0, M1, M2    in   2      ALU operand A, operand B, S source selects
//   completed     in   1      controller done level
//   x_in..c_in    in   WIDTH  input x and coefficients a, b, c
//   result        out  WIDTH  captured S value
//   result_valid  out  1      one-cycle pulse on capture
//   result_ovf    out  1      overflow flag captured with result
//   busy_ovf      out  1      sticky overflow of the current evaluation
// ---------------------------------------------------------------------------
module expr_datapath
   import expr_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             LX,
   input  logic             LS,
   input  logic             LH,
   input  logic             H,
   input  logic [1:0]       M0,
   input  logic [1:0]       M1,
   input  logic [1:0]       M2,
   input  logic             completed,
   input  logic [WIDTH-1:0] x_in,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic [WIDTH-1:0] c_in,
   output logic [WIDTH-1:0] result,
   output logic             result_valid,
   output logic             result_ovf,
   output logic             busy_ovf
);

   logic [WIDTH-1:0] x_q, x_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic [WIDTH-1:0] hr_q, hr_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             result_valid_q, result_valid_d;
   logic             result_ovf_q, result_ovf_d;
   logic             busy_ovf_q, busy_ovf_d;
   logic             completed_q, completed_d;

   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [WIDTH-1:0] alu_out;
   logic             alu_ovf;
   logic [WIDTH-1:0] s_src;
   logic             ovf_set;
   logic             capture;

   // Operand and S-source multiplexers; every select code is decoded.
   always_comb begin
      unique case (M0)
         SEL_A_X:  alu_a = x_q;
         SEL_A_S:  alu_a = s_q;
         SEL_A_HR: alu_a = hr_q;
         default:  alu_a = '0;
      endcase
      unique case (M1)
         SEL_B_C: alu_b = c_in;
         SEL_B_A: alu_b = a_in;
         SEL_B_B: alu_b = b_in;
         default: alu_b = x_q;
      endcase
      unique case (M2)
         SEL_S_ALU: s_src = alu_out;
         SEL_S_X:   s_src = x_q;
         SEL_S_HR:  s_src = hr_q;
         default:   s_src = '0;
      endcase
   end

   expr_alu #(
      .WIDTH (WIDTH)
   ) u_alu (
      .op     (H),
      .opa    (alu_a),
      .opb    (alu_b),
      .result (alu_out),
      .ovf    (alu_ovf)
   );

   // Next-state logic.  All loads read pre-edge register values, so
   // simultaneous strobes compose without ordering effects.  LX starts a
   // new evaluation, so its clear of busy_ovf beats a coincident set.
   // Capture takes the pre-edge S, ignoring any LS in the same cycle.
   always_comb begin
      x_d  = LX ? x_in    : x_q;
      hr_d = LH ? alu_out : hr_q;
      s_d  = LS ? s_src   : s_q;

      ovf_set = alu_ovf & (LH | (LS & (M2 == SEL_S_ALU)));
      if (LX) begin
         busy_ovf_d = 1'b0;
      end else if (ovf_set) begin
         busy_ovf_d = 1'b1;
      end else begin
         busy_ovf_d = busy_ovf_q;
      end

      completed_d    = completed;
      capture        = completed & ~completed_q;
      result_valid_d = capture;
      result_d       = capture ? s_q        : result_q;
      result_ovf_d   = capture ? busy_ovf_q : result_ovf_q;
   end

   // State registers with asynchronous active-low clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         x_q            <= '0;
         s_q            <= '0;
         hr_q           <= '0;
         result_q       <= '0;
         result_valid_q <= 1'b0;
         result_ovf_q   <= 1'b0;
         busy_ovf_q     <= 1'b0;
         completed_q    <= 1'b0;
      end else begin
         x_q            <= x_d;
         s_q            <= s_d;
         hr_q           <= hr_d;
         result_q       <= result_d;
         result_valid_q <= result_valid_d;
         result_ovf_q   <= result_ovf_d;
         busy_ovf_q     <= busy_ovf_d;
         completed_q    <= completed_d;
      end
   end

   assign result       = result_q;
   assign result_valid = result_valid_q;
   assign result_ovf   = result_ovf_q;
   assign busy_ovf     = busy_ovf_q;

endmodule

// File: tb/tb_expr_datapath.sv
// ---------------------------------------------------------------------------
// tb_expr_datapath
// Directed, table-driven bench for expr_datapath (WIDTH = 8).  Each table
// row is one clock cycle of controller strobes plus the register and output
// values expected after that edge.  Hand-written sequences follow for the
// completed-hold, capture-vs-LS and asynchronous reset cases.
// ---------------------------------------------------------------------------
module tb_expr_datapath;

   localparam int W = 8;

   // Values written on overflow depend on whether saturation is built in.
`ifdef SATURATE_EN
   localparam logic [W-1:0] MUL_400 = 8'd255;
   localparam logic [W-1:0] MUL_270 = 8'd255;
   localparam logic [W-1:0] ADD_300 = 8'd255;
`else
   localparam logic [W-1:0] MUL_400 = 8'd144;
   localparam logic [W-1:0] MUL_270 = 8'd14;
   localparam logic [W-1:0] ADD_300 = 8'd44;
`endif

   typedef struct {
      string        name;
      logic         lx, ls, lh, h;
      logic [1:0]   m0, m1, m2;
      logic         comp;
      logic [W-1:0] x, a, b, c;
      logic [W-1:0] exp_x, exp_s, exp_hr, exp_res;
      logic         exp_valid, exp_rovf, exp_bovf;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         LX, LS, LH, H, completed;
   logic [1:0]   M0, M1, M2;
   logic [W-1:0] x_in, a_in, b_in, c_in;
   logic [W-1:0] result;
   logic         result_valid, result_ovf, busy_ovf;

   int checks = 0;
   int errors = 0;

   vec_t vecs[$];

   expr_datapath #(
      .WIDTH (W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .LX           (LX),
      .LS           (LS),
      .LH           (LH),
      .H            (H),
      .M0           (M0),
      .M1           (M1),
      .M2           (M2),
      .completed    (completed),
      .x_in         (x_in),
      .a_in         (a_in),
      .b_in         (b_in),
      .c_in         (c_in),
      .result       (result),
      .result_valid (result_valid),
      .result_ovf   (result_ovf),
      .busy_ovf     (busy_ovf)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   // Safety net so the run always terminates.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic vec_t mk(string name,
                               logic lx, logic ls, logic lh, logic h,
                               logic [1:0] m0, logic [1:0] m1, logic [1:0] m2,
                               logic comp,
                               logic [W-1:0] x, logic [W-1:0] a,
                               logic [W-1:0] b, logic [W-1:0] c,
                               logic [W-1:0] ex, logic [W-1:0] es,
                               logic [W-1:0] ehr, logic [W-1:0] eres,
                               logic ev, logic erovf, logic ebovf);
      vec_t v;
      v.name = name;
      v.lx = lx; v.ls = ls; v.lh = lh; v.h = h;
      v.m0 = m0; v.m1 = m1; v.m2 = m2; v.comp = comp;
      v.x = x; v.a = a; v.b = b; v.c = c;
      v.exp_x = ex; v.exp_s = es; v.exp_hr = ehr; v.exp_res = eres;
      v.exp_valid = ev; v.exp_rovf = erovf; v.exp_bovf = ebovf;
      return v;
   endfunction

   // Drive one cycle of controller inputs and advance past the next edge.
   task automatic applyStimulus(logic lx, logic ls, logic lh, logic h,
                                logic [1:0] m0, logic [1:0] m1, logic [1:0] m2,
                                logic comp, logic [W-1:0] x, logic [W-1:0] a,
                                logic [W-1:0] b, logic [W-1:0] c);
      LX = lx; LS = ls; LH = lh; H = h;
      M0 = m0; M1 = m1; M2 = m2; completed = comp;
      x_in = x; a_in = a; b_in = b; c_in = c;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(string tag, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   initial begin
      int pulses;

      // ---------------- vector table ----------------
      // name                lx ls lh h  m0     m1     m2     cp x    a    b   c   X    S        Hr       Res      v  ro bo
      vecs.push_back(mk("horner_lx",   1,0,0,0, 2'b00,2'b00,2'b00,0, 5,   2,   3,  4,  5,   0,       0,       0,       0,0,0));
      vecs.push_back(mk("horner_xa",   0,0,1,1, 2'b00,2'b01,2'b00,0, 0,   2,   3,  4,  5,   0,       10,      0,       0,0,0));
      vecs.push_back(mk("horner_pb",   0,1,0,0, 2'b10,2'b10,2'b00,0, 0,   2,   3,  4,  5,   13,      10,      0,       0,0,0));
      vecs.push_back(mk("horner_sx",   0,0,1,1, 2'b01,2'b11,2'b00,0, 0,   2,   3,  4,  5,   13,      65,      0,       0,0,0));
      vecs.push_back(mk("horner_pc",   0,1,0,0, 2'b10,2'b00,2'b00,0, 0,   2,   3,  4,  5,   69,      65,      0,       0,0,0));
      vecs.push_back(mk("horner_cap",  0,0,0,0, 2'b00,2'b00,2'b00,1, 0,   2,   3,  4,  5,   69,      65,      69,      1,0,0));
      vecs.push_back(mk("horner_hold", 0,0,0,0, 2'b00,2'b00,2'b00,1, 0,   2,   3,  4,  5,   69,      65,      69,      0,0,0));
      vecs.push_back(mk("horner_drop", 0,0,0,0, 2'b00,2'b00,2'b00,0, 0,   2,   3,  4,  5,   69,      65,      69,      0,0,0));
      vecs.push_back(mk("ovf_lx",      1,0,0,0, 2'b00,2'b00,2'b00,0, 20,  20,  3,  4,  20,  69,      65,      69,      0,0,0));
      vecs.push_back(mk("ovf_mul",     0,0,1,1, 2'b00,2'b01,2'b00,0, 0,   20,  3,  4,  20,  69,      MUL_400, 69,      0,0,1));
      vecs.push_back(mk("ovf_s_hr",    0,1,0,0, 2'b00,2'b00,2'b10,0, 0,   20,  3,  4,  20,  MUL_400, MUL_400, 69,      0,0,1));
      vecs.push_back(mk("ovf_cap",     0,0,0,0, 2'b00,2'b00,2'b00,1, 0,   20,  3,  4,  20,  MUL_400, MUL_400, MUL_400, 1,1,1));
      vecs.push_back(mk("ovf_clear",   1,0,0,0, 2'b00,2'b00,2'b00,0, 9,   20,  3,  4,  9,   MUL_400, MUL_400, MUL_400, 0,1,0));
      vecs.push_back(mk("sim_pre",     1,0,0,0, 2'b00,2'b00,2'b00,0, 7,   0,   0,  0,  7,   MUL_400, MUL_400, MUL_400, 0,1,0));
      vecs.push_back(mk("sim_lx_ls",   1,1,0,0, 2'b00,2'b00,2'b01,0, 9,   0,   0,  0,  9,   7,       MUL_400, MUL_400, 0,1,0));
      vecs.push_back(mk("clr_vs_set",  1,0,1,1, 2'b00,2'b10,2'b00,0, 3,   0,   30, 0,  3,   7,       MUL_270, MUL_400, 0,1,0));
      vecs.push_back(mk("s_zero",      0,1,0,0, 2'b00,2'b00,2'b11,0, 0,   0,   30, 0,  3,   0,       MUL_270, MUL_400, 0,1,0));
      vecs.push_back(mk("zero_plus_x", 0,0,1,0, 2'b11,2'b11,2'b00,0, 0,   0,   30, 0,  3,   0,       3,       MUL_400, 0,1,0));
      vecs.push_back(mk("add_lx",      1,0,0,0, 2'b00,2'b00,2'b00,0, 200, 100, 0,  0,  200, 0,       3,       MUL_400, 0,1,0));
      vecs.push_back(mk("add_ovf",     0,1,0,0, 2'b00,2'b01,2'b00,0, 0,   100, 0,  0,  200, ADD_300, 3,       MUL_400, 0,1,1));
      vecs.push_back(mk("add_cap",     0,0,0,0, 2'b00,2'b00,2'b00,1, 0,   100, 0,  0,  200, ADD_300, 3,       ADD_300, 1,1,1));
      vecs.push_back(mk("add_drop",    0,0,0,0, 2'b00,2'b00,2'b00,0, 0,   100, 0,  0,  200, ADD_300, 3,       ADD_300, 0,1,1));

      // ---------------- reset state ----------------
      rst = 1'b0;
      LX = 0; LS = 0; LH = 0; H = 0; M0 = 0; M1 = 0; M2 = 0; completed = 0;
      x_in = 0; a_in = 0; b_in = 0; c_in = 0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_result", result, 0);
      checkOutput("reset_valid", result_valid, 0);
      checkOutput("reset_rovf", result_ovf, 0);
      checkOutput("reset_bovf", busy_ovf, 0);
      rst = 1'b1;

      // ---------------- table ----------------
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].lx, vecs[i].ls, vecs[i].lh, vecs[i].h,
                       vecs[i].m0, vecs[i].m1, vecs[i].m2, vecs[i].comp,
                       vecs[i].x, vecs[i].a, vecs[i].b, vecs[i].c);
         checkOutput({vecs[i].name, "_X"}, dut.x_q, vecs[i].exp_x);
         checkOutput({vecs[i].name, "_S"}, dut.s_q, vecs[i].exp_s);
         checkOutput({vecs[i].name, "_Hr"}, dut.hr_q, vecs[i].exp_hr);
         checkOutput({vecs[i].name, "_result"}, result, vecs[i].exp_res);
         checkOutput({vecs[i].name, "_valid"}, result_valid, vecs[i].exp_valid);
         checkOutput({vecs[i].name, "_rovf"}, result_ovf, vecs[i].exp_rovf);
         checkOutput({vecs[i].name, "_bovf"}, busy_ovf, vecs[i].exp_bovf);
      end

      // ---------------- completed held for five cycles ----------------
      // X = 200, busy_ovf = 1 from the overflowing add.
      applyStimulus(0,1,0,0, 2'b00,2'b00,2'b01, 0, 0,0,0,0);
      checkOutput("hold_S200", dut.s_q, 200);
      pulses = 0;
      for (int k = 0; k < 5; k++) begin
         applyStimulus(0,0,0,0, 2'b00,2'b00,2'b00, 1, 0,0,0,0);
         if (result_valid === 1'b1) pulses++;
      end
      checkOutput("hold_pulses", pulses, 1);
      checkOutput("hold_result", result, 200);
      checkOutput("hold_rovf", result_ovf, 1);

      // Drop, start a fresh evaluation, re-raise: second pulse, new S.
      applyStimulus(1,0,0,0, 2'b00,2'b00,2'b00, 0, 17,0,0,0);
      checkOutput("rearm_bovf_clr", busy_ovf, 0);
      applyStimulus(0,1,0,0, 2'b00,2'b00,2'b01, 0, 0,0,0,0);
      applyStimulus(0,0,0,0, 2'b00,2'b00,2'b00, 1, 0,0,0,0);
      checkOutput("rearm_valid", result_valid, 1);
      checkOutput("rearm_result", result, 17);
      checkOutput("rearm_rovf", result_ovf, 0);

      // ---------------- LS coincident with capture ----------------
      applyStimulus(0,0,0,0, 2'b00,2'b00,2'b00, 0, 0,0,0,0);
      applyStimulus(0,1,0,0, 2'b00,2'b00,2'b11, 1, 0,0,0,0);
      checkOutput("capls_valid", result_valid, 1);
      checkOutput("capls_result", result, 17);
      checkOutput("capls_S", dut.s_q, 0);

      // ---------------- asynchronous reset mid-run ----------------
      applyStimulus(1,0,0,0, 2'b00,2'b00,2'b00, 0, 69,0,0,0);
      applyStimulus(0,0,1,1, 2'b00,2'b11,2'b00, 0, 0,0,0,0);
      checkOutput("rst_pre_bovf", busy_ovf, 1);
      applyStimulus(0,1,0,0, 2'b00,2'b00,2'b01, 0, 0,0,0,0);
      checkOutput("rst_pre_S", dut.s_q, 69);
      applyStimulus(0,0,0,0, 2'b00,2'b00,2'b00, 1, 0,0,0,0);
      checkOutput("rst_pre_valid", result_valid, 1);
      checkOutput("rst_pre_result", result, 69);
      #2;
      rst = 1'b0;
      #1;
      checkOutput("rst_async_result", result, 0);
      checkOutput("rst_async_valid", result_valid, 0);
      checkOutput("rst_async_rovf", result_ovf, 0);
      checkOutput("rst_async_bovf", busy_ovf, 0);
      checkOutput("rst_async_S", dut.s_q, 0);
      checkOutput("rst_async_X", dut.x_q, 0);
      checkOutput("rst_async_Hr", dut.hr_q, 0);
      completed = 0;
      @(posedge clk);
      #1;
      rst = 1'b1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
